// File: rtl/contra_snd_pkg.sv
// contra_snd_pkg: shared definitions for the Contra sound-board serial audio path.
//   SLOT_BITS / FRAME_BITS : I2S slot and frame geometry (32-bit slots, 64-BCK frame)
//   chan_e                 : channel selected by the word-select line
//   slot_sel()             : maps a frame bit count onto channel, slot bit index and
//                            a valid flag (false for the delay bit and the pad bits)
package contra_snd_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  typedef struct packed {
    logic       valid;
    chan_e      chan;
    logic [4:0] idx;
  } slot_sel_t;

  // Position p=0 is the one-BCK I2S delay; p=1..dw carries sample bit dw-p (MSB first).
  function automatic slot_sel_t slot_sel(input logic [BIT_CNT_W-1:0] b,
                                         input logic [BIT_CNT_W-1:0] dw);
    slot_sel_t            s;
    logic [BIT_CNT_W-1:0] p;
    p       = {1'b0, b[BIT_CNT_W-2:0]};
    s.chan  = chan_e'(b[BIT_CNT_W-1]);
    s.valid = (p != '0) && (p <= dw);
    s.idx   = 5'(dw - p);
    return s;
  endfunction

endpackage

// File: rtl/contra_snd_i2s_tx_bck_div.sv
// contra_snd_bck_div: bit-clock divider with a fall-event strobe.
//   clk, rst_n : base clock, asynchronous active-low reset
//   bck        : divided clock, registered, toggles every BCK_DIV clk cycles
//   fall       : high in the clk cycle whose edge takes bck from 1 to 0
module contra_snd_bck_div #(
  parameter int unsigned BCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic bck,
  output logic fall
);

  localparam int unsigned CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [CW-1:0] div_cnt_d, div_cnt_q;
  logic          bck_d, bck_q;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == CW'(BCK_DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + CW'(1);
    bck_d     = wrap ? ~bck_q : bck_q;
    fall      = wrap & bck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

  assign bck = bck_q;

endmodule

// File: rtl/contra_snd_i2s_tx.sv
// contra_snd_i2s_tx: double-buffered Philips-I2S transmitter for the external DAC.
//   clk, rst_n          : 14.28 MHz base clock, asynchronous active-low reset
//   left, right         : two's complement samples, captured on sample_valid
//   sample_valid        : one-cycle strobe
//   bck, lrck, sdata    : I2S outputs; lrck/sdata change only when bck falls
//   underrun            : pulse when a frame starts without a fresh sample
//   overrun             : pulse when a held sample is overwritten unsent
module contra_snd_i2s_tx #(
  parameter int unsigned BCK_DIV = 2,
  parameter int unsigned DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  input  logic          sample_valid,
  output logic          bck,
  output logic          lrck,
  output logic          sdata,
  output logic          underrun,
  output logic          overrun
);

  import contra_snd_pkg::*;

  logic                 fall;
  logic [BIT_CNT_W-1:0] bit_cnt_d, bit_cnt_q, bit_nxt;
  logic                 lrck_d, lrck_q;
  logic                 sdata_d, sdata_q;
  logic [DW-1:0]        hold_l_d, hold_l_q, hold_r_d, hold_r_q;
  logic [DW-1:0]        slot_l_d, slot_l_q, slot_r_d, slot_r_q;
  logic                 full_d, full_q;
  logic                 primed_d, primed_q;
  logic                 underrun_d, underrun_q;
  logic                 overrun_d, overrun_q;
  logic                 load;
  slot_sel_t            sel;
  logic [SLOT_BITS-1:0] slot_word;

  contra_snd_bck_div #(.BCK_DIV(BCK_DIV)) u_bck_div (
    .clk   (clk),
    .rst_n (rst_n),
    .bck   (bck),
    .fall  (fall)
  );

  always_comb begin
    bit_nxt = bit_cnt_q + BIT_CNT_W'(1);
    load    = fall && (bit_nxt == '0);
    sel     = slot_sel(bit_nxt, BIT_CNT_W'(DW));

    slot_word = '0;
    slot_word[DW-1:0] = (sel.chan == CH_RIGHT) ? slot_r_q : slot_l_q;

    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    if (fall) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = bit_nxt[BIT_CNT_W-1];
      sdata_d   = sel.valid & slot_word[sel.idx];
    end

    // Slots keep their contents when nothing new is held, so the last
    // sample repeats on underrun.
    slot_l_d = slot_l_q;
    slot_r_d = slot_r_q;
    if (load && full_q) begin
      slot_l_d = hold_l_q;
      slot_r_d = hold_r_q;
    end

    // A strobe coinciding with the load wins over the clear, so the new
    // sample stays pending for the next frame.
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    if (load) full_d = 1'b0;
    if (sample_valid) begin
      hold_l_d = left;
      hold_r_d = right;
      full_d   = 1'b1;
    end

    primed_d   = primed_q | sample_valid;
    underrun_d = load & ~full_q & primed_q;
    overrun_d  = sample_valid & full_q & ~load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '1;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      slot_l_q   <= '0;
      slot_r_q   <= '0;
      full_q     <= 1'b0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      slot_l_q   <= slot_l_d;
      slot_r_q   <= slot_r_d;
      full_q     <= full_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule
